// File: rtl/index_to_2d.sv
// Linear index -> (x, y) recovery: x = index / width, y = index % width via a
// restoring divider, one quotient bit per clock. Optional macro FRAME_BOUNDS_EN flags x >= HEIGHT.
module index_to_2d #(
  parameter int IDX_W   = 14,
  parameter int COORD_W = 8,
  parameter int HEIGHT  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IDX_W-1:0]   index,
  input  logic [COORD_W-1:0] width,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               err
);

  localparam int CNT_W = (IDX_W > 1) ? $clog2(IDX_W) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IDX_W - 1);
  localparam logic [31:0] X_MAX = 32'((64'd1 << COORD_W) - 64'd1);
`ifdef FRAME_BOUNDS_EN
  localparam bit FRAME_EN = 1'b1;
`else
  localparam bit FRAME_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [COORD_W-1:0] width_r;
  logic [COORD_W:0]   rem_r;
  logic [IDX_W-1:0]   quot_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [COORD_W+1:0] rem_shift_s;
  logic               ge_s;
  logic [COORD_W:0]   rem_next_s;
  logic [IDX_W-1:0]   quot_next_s;
  logic               ovf_s;
  logic [COORD_W-1:0] x_fin_s;
  logic               frame_hit_s;
  logic               err_fin_s;

  // One restoring-division step; idx_r is shifted so its MSB is the next dividend bit.
  always_comb begin
    rem_shift_s = {rem_r, idx_r[IDX_W-1]};
    ge_s        = (rem_shift_s >= {2'b00, width_r});
    if (ge_s) begin
      rem_next_s = (COORD_W+1)'(rem_shift_s - {2'b00, width_r});
    end else begin
      rem_next_s = (COORD_W+1)'(rem_shift_s);
    end
    quot_next_s = IDX_W'({quot_r, ge_s});
    ovf_s       = ({{(32-IDX_W){1'b0}}, quot_next_s} > X_MAX);
    if (ovf_s) begin
      x_fin_s = {COORD_W{1'b1}};
    end else begin
      x_fin_s = COORD_W'(quot_next_s);
    end
    frame_hit_s = ({{(32-COORD_W){1'b0}}, x_fin_s} >= 32'(HEIGHT));
    err_fin_s   = ovf_s | (FRAME_EN & frame_hit_s);
  end

  // Control FSM, divider datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
      width_r <= {COORD_W{1'b0}};
      rem_r   <= {(COORD_W+1){1'b0}};
      quot_r  <= {IDX_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      x       <= {COORD_W{1'b0}};
      y       <= {COORD_W{1'b0}};
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        // FIN accepts a new request exactly like IDLE so operations can run back to back.
        IDLE, FIN: begin
          if (start) begin
            if (width != {COORD_W{1'b0}}) begin
              idx_r   <= index;
              width_r <= width;
              rem_r   <= {(COORD_W+1){1'b0}};
              quot_r  <= {IDX_W{1'b0}};
              cnt_r   <= CNT_INIT;
              busy    <= 1'b1;
              state_r <= DIV;
            end else begin
              x       <= {COORD_W{1'b0}};
              y       <= {COORD_W{1'b0}};
              err     <= 1'b1;
              done    <= 1'b1;
              state_r <= FIN;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        DIV: begin
          rem_r  <= rem_next_s;
          quot_r <= quot_next_s;
          idx_r  <= {idx_r[IDX_W-2:0], 1'b0};
          if (cnt_r == {CNT_W{1'b0}}) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            x       <= x_fin_s;
            y       <= rem_next_s[COORD_W-1:0];
            err     <= err_fin_s;
            state_r <= FIN;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
